// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake and status bundle between a FIFO pointer controller and the logic that uses it.
// The controller takes the slave modport; the requester (and its storage) takes the master modport.
interface fifo_ptr_ctrl_if #(
    parameter int unsigned MAIN_SIZE = 4
) ();

    // Requests into the controller
    logic                 push;
    logic                 pop;

    // Storage strobes and addresses
    logic                 write;
    logic                 read;
    logic [MAIN_SIZE-1:0] wr_ptr;
    logic [MAIN_SIZE-1:0] rd_ptr;

    // Occupancy and status
    logic [MAIN_SIZE-1:0] count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 overflow;
    logic                 underflow;

    modport slave (
        input  push,
        input  pop,
        output write,
        output read,
        output wr_ptr,
        output rd_ptr,
        output count,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output overflow,
        output underflow
    );

    modport master (
        output push,
        output pop,
        input  write,
        input  read,
        input  wr_ptr,
        input  rd_ptr,
        input  count,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  overflow,
        input  underflow
    );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer controller: owns the write/read addresses, the occupancy count and the
// status flags for an external storage array with a combinational read port.
// Optional feature: define FIFO_ALMOST_FLAGS_EN to enable the almost_full/almost_empty
// threshold decode; otherwise both flags are tied low and no threshold logic is built.
module fifo_ptr_ctrl #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned MAIN_SIZE = 4,
    parameter int unsigned AF_LEVEL  = 3,
    parameter int unsigned AE_LEVEL  = 1
) (
    input logic            clk,
    input logic            reset,
    fifo_ptr_ctrl_if.slave bus
);

    // Pointers wrap at MAIN_SIZE-1; count needs to reach MAIN_SIZE, which fits in
    // MAIN_SIZE bits for any depth of 2 or more.
    localparam logic [MAIN_SIZE-1:0] LastIdx = MAIN_SIZE'(MAIN_SIZE - 1);
    localparam logic [MAIN_SIZE-1:0] FullCnt = MAIN_SIZE'(MAIN_SIZE);

    // Elaboration-time sanity checks on the configuration
    if (MAIN_SIZE < 2) begin : g_bad_main_size
        $error("fifo_ptr_ctrl: MAIN_SIZE must be at least 2");
    end
    if (DATA_SIZE == 0) begin : g_bad_data_size
        $error("fifo_ptr_ctrl: DATA_SIZE must be non-zero");
    end
    if ((AF_LEVEL > MAIN_SIZE) || (AE_LEVEL > MAIN_SIZE)) begin : g_bad_levels
        $error("fifo_ptr_ctrl: almost thresholds must not exceed MAIN_SIZE");
    end

    logic [MAIN_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAIN_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAIN_SIZE-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic full_raw;
    logic empty_raw;
    logic push_ok;
    logic pop_ok;

    assign full_raw  = (count_q == FullCnt);
    assign empty_raw = (count_q == '0);

    // Acceptance: a push into a full FIFO is allowed only when a pop frees the slot in the
    // same cycle. Nothing is accepted while reset is high so the storage never sees a strobe.
    always_comb begin
        push_ok = bus.push & (~full_raw | bus.pop) & ~reset;
        pop_ok  = bus.pop & ~empty_raw & ~reset;
    end

    // Next-state for pointers, occupancy and sticky error flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A request that was made but not accepted is an error and stays recorded
        if (bus.push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (bus.pop && !pop_ok) begin
            underflow_d = 1'b1;
        end
    end

    // State registers with synchronous reset; reset drops all occupancy in one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Strobes and addresses; addresses always show the slot a strobe would use this cycle
    assign bus.write     = push_ok;
    assign bus.read      = pop_ok;
    assign bus.wr_ptr    = wr_ptr_q;
    assign bus.rd_ptr    = rd_ptr_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // Status decode from the registered count, forced to the empty view while in reset
    assign bus.full  = full_raw & ~reset;
    assign bus.empty = empty_raw | reset;

`ifdef FIFO_ALMOST_FLAGS_EN
    logic [31:0] count_ext;

    assign count_ext = 32'(count_q);

    // Threshold decode, compared at full integer width so any level setting is exact
    always_comb begin
        bus.almost_full  = (count_ext >= AF_LEVEL) & ~reset;
        bus.almost_empty = (count_ext <= AE_LEVEL) | reset;
    end
`else
    assign bus.almost_full  = 1'b0;
    assign bus.almost_empty = 1'b0;
`endif

endmodule
